// File: rtl/definitions_pkg.sv
// Shared types and default image geometry for the Canny edge pipeline.
package definitions_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;

endpackage

// File: rtl/canny_pos_counter.sv
// Raster position counter: column wraps at W-1 and carries into row, row wraps at H-1.
module canny_pos_counter #(
  parameter int W = 512,
  parameter int H = 512
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 step,
  input  logic                 clr,
  output logic [$clog2(W)-1:0] col,
  output logic [$clog2(H)-1:0] row,
  output logic                 last
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  always_ff @(posedge clk) begin
    if (!rstN || clr) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer: gates stream handshakes, issues the pipeline advance enable,
// drains with flush cycles after the last input and tags outputs with position sideband.
module canny_frame_ctrl
  import definitions_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int LAT   = 2 * IMG_W + 6
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     start,
  input  logic                     pixel_in_valid,
  output logic                     in_ready,
  input  logic                     out_ready,
  output logic                     pixel_out_valid,
  output logic                     advance,
  output logic                     flush,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic                     out_border,
  output logic                     out_eol,
  output logic                     out_sof,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int AW    = $clog2(TOTAL + LAT + 1);
  localparam int OW    = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

  localparam logic [AW-1:0] ADV_END  = AW'(TOTAL + LAT);
  localparam logic [AW:0]   LAT_EXT  = (AW + 1)'(LAT);
  localparam logic [OW-1:0] OUT_LAST = OW'(TOTAL - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);

  ctrl_state_t   state, state_nxt;
  logic [AW-1:0] adv_cnt;
  logic [OW-1:0] out_cnt;
  logic          slot, accept, consume, frame_end, clr;
  logic          in_last;
  logic [CW-1:0] unused_in_col;
  logic [RW-1:0] unused_in_row;
  logic          unused_out_last;

  assign slot      = !pixel_out_valid || out_ready;
  assign accept    = pixel_in_valid && in_ready;
  assign consume   = pixel_out_valid && out_ready;
  assign frame_end = consume && (out_cnt == OUT_LAST);
  assign clr       = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    advance    = 1'b0;
    flush      = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        in_ready = slot;
        advance  = pixel_in_valid && slot;
        if (pixel_in_valid && slot && in_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Flush stays asserted only while drain advances are still owed.
        flush   = (adv_cnt < ADV_END);
        advance = slot && (adv_cnt < ADV_END);
        if (frame_end) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      adv_cnt         <= '0;
      out_cnt         <= '0;
      pixel_out_valid <= 1'b0;
    end else begin
      if (clr)          adv_cnt <= '0;
      else if (advance) adv_cnt <= adv_cnt + 1'b1;

      if (clr)          out_cnt <= '0;
      else if (consume) out_cnt <= out_cnt + 1'b1;

      // The first LAT advances only fill the pipeline; later ones produce a pixel.
      if (advance)      pixel_out_valid <= (({1'b0, adv_cnt} + 1'b1) > LAT_EXT);
      else if (consume) pixel_out_valid <= 1'b0;
    end
  end

  canny_pos_counter #(.W(IMG_W), .H(IMG_H)) u_in_pos (
    .clk  (clk),
    .rstN (rstN),
    .step (accept),
    .clr  (clr),
    .col  (unused_in_col),
    .row  (unused_in_row),
    .last (in_last)
  );

  canny_pos_counter #(.W(IMG_W), .H(IMG_H)) u_out_pos (
    .clk  (clk),
    .rstN (rstN),
    .step (consume),
    .clr  (clr),
    .col  (out_col),
    .row  (out_row),
    .last (unused_out_last)
  );

  assign out_eol    = (out_col == COL_MAX);
  assign out_sof    = (out_col == '0) && (out_row == '0);
  assign out_border = (out_col == '0) || (out_col == COL_MAX) ||
                      (out_row == '0) || (out_row == ROW_MAX);

endmodule
